// File: rtl/vm_vend_ctrl.sv
// Vending controller core: per-slot stock/cost tables, coin credit
// accumulation, purchase/cancel/timeout FSM with registered pulses.
module vm_vend_ctrl #(
    parameter int NUM_ITEMS = 8,
    parameter int CNT_W     = 4,
    parameter int COST_W    = 8,
    parameter int AMT_W     = 16,
    parameter int TIMEOUT   = 512,
    localparam int IDX_W    = $clog2(NUM_ITEMS)
) (
    input  logic              clk,
    input  logic              hrst,
    input  logic              srst,
    input  logic              sup_valid,
    input  logic [IDX_W-1:0]  sup_item,
    input  logic [CNT_W-1:0]  sup_count,
    input  logic [COST_W-1:0] sup_cost,
    input  logic              coin_valid,
    input  logic [COST_W-1:0] coin_value,
    output logic              coin_ready,
    input  logic [IDX_W-1:0]  button,
    input  logic              select,
    input  logic              cancel,
    output logic [IDX_W-1:0]  product,
    output logic              product_valid,
    output logic [AMT_W-1:0]  balance,
    output logic              change_valid,
    output logic [7:0]        info,
    output logic [2:0]        status
);

    localparam int TMR_W = $clog2(TIMEOUT);
    localparam logic [TMR_W-1:0] RELOAD = TMR_W'(TIMEOUT - 1);

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_COLLECT = 3'd1;
    localparam logic [2:0] ST_VENDED  = 3'd2;
    localparam logic [2:0] ST_SOLDOUT = 3'd3;
    localparam logic [2:0] ST_INSUFF  = 3'd4;
    localparam logic [2:0] ST_REFUND  = 3'd5;
    localparam logic [2:0] ST_TIMEOUT = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_REFUND
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  count_q [NUM_ITEMS];
    logic [CNT_W-1:0]  count_d [NUM_ITEMS];
    logic [COST_W-1:0] cost_q  [NUM_ITEMS];
    logic [COST_W-1:0] cost_d  [NUM_ITEMS];
    logic [AMT_W-1:0]  credit_q, credit_d;
    logic [AMT_W-1:0]  balance_q, balance_d;
    logic [TMR_W-1:0]  timer_q, timer_d;
    logic [IDX_W-1:0]  product_q, product_d;
    logic              pv_q, pv_d;
    logic              cv_q, cv_d;
    logic [7:0]        info_q, info_d;
    logic [2:0]        status_q, status_d;

    logic              coin_acc;
    logic              slot_ok;
    logic [AMT_W:0]    sum;
    logic [AMT_W-1:0]  credit_p;
    logic [AMT_W-1:0]  cost_sel;
    logic [AMT_W-1:0]  short_amt;

    assign coin_ready = (state_q == S_IDLE) || (state_q == S_COLLECT);
    assign coin_acc   = coin_valid && coin_ready;
    assign sum        = {1'b0, credit_q} + (AMT_W+1)'(coin_value);
    // Credit as seen by this cycle's decision: the coin lands first, saturating.
    assign credit_p   = !coin_acc     ? credit_q :
                        sum[AMT_W]    ? '1       : sum[AMT_W-1:0];
    assign slot_ok    = 32'(button) < 32'(NUM_ITEMS);
    assign cost_sel   = slot_ok ? AMT_W'(cost_q[button]) : '0;
    assign short_amt  = cost_sel - credit_p;

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        cost_d    = cost_q;
        credit_d  = credit_q;
        balance_d = balance_q;
        timer_d   = timer_q;
        product_d = product_q;
        pv_d      = 1'b0;
        cv_d      = 1'b0;
        info_d    = 8'h00;
        status_d  = status_q;
        unique case (state_q)
            S_IDLE: begin
                status_d = ST_IDLE;
                if (sup_valid) begin
                    count_d[sup_item] = sup_count;
                    cost_d[sup_item]  = sup_cost;
                end
                if (coin_acc) begin
                    credit_d = AMT_W'(coin_value);
                    timer_d  = RELOAD;
                    state_d  = S_COLLECT;
                    status_d = ST_COLLECT;
                end
            end
            S_COLLECT: begin
                credit_d = credit_p;
                status_d = ST_COLLECT;
                if (coin_acc && sum[AMT_W]) begin
                    info_d = 8'hFF;
                end
                if (cancel) begin
                    cv_d      = 1'b1;
                    balance_d = credit_p;
                    credit_d  = '0;
                    state_d   = S_REFUND;
                    status_d  = ST_REFUND;
                end else if (select && (!slot_ok || count_q[button] == '0)) begin
                    info_d   = 8'(button);
                    status_d = ST_SOLDOUT;
                    timer_d  = RELOAD;
                end else if (select && credit_p < cost_sel) begin
                    info_d   = 8'(short_amt);
                    status_d = ST_INSUFF;
                    timer_d  = RELOAD;
                end else if (select) begin
                    pv_d            = 1'b1;
                    product_d       = button;
                    count_d[button] = count_q[button] - CNT_W'(1);
                    credit_d        = credit_p - cost_sel;
                    state_d         = S_VEND;
                    status_d        = ST_VENDED;
                end else if (coin_acc) begin
                    timer_d = RELOAD;
                end else if (timer_q == '0) begin
                    cv_d      = 1'b1;
                    balance_d = credit_q;
                    credit_d  = '0;
                    state_d   = S_REFUND;
                    status_d  = ST_TIMEOUT;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
            S_VEND: begin
                if (credit_q != '0) begin
                    cv_d      = 1'b1;
                    balance_d = credit_q;
                    credit_d  = '0;
                    state_d   = S_REFUND;
                end else begin
                    state_d  = S_IDLE;
                    status_d = ST_IDLE;
                end
            end
            S_REFUND: begin
                state_d  = S_IDLE;
                status_d = ST_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                status_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge hrst) begin
        if (!hrst) begin
            state_q   <= S_IDLE;
            count_q   <= '{default: '0};
            cost_q    <= '{default: '0};
            credit_q  <= '0;
            balance_q <= '0;
            timer_q   <= '0;
            product_q <= '0;
            pv_q      <= 1'b0;
            cv_q      <= 1'b0;
            info_q    <= 8'h00;
            status_q  <= ST_IDLE;
        end else if (srst) begin
            state_q   <= S_IDLE;
            count_q   <= '{default: '0};
            cost_q    <= '{default: '0};
            credit_q  <= '0;
            balance_q <= '0;
            timer_q   <= '0;
            product_q <= '0;
            pv_q      <= 1'b0;
            cv_q      <= 1'b0;
            info_q    <= 8'h00;
            status_q  <= ST_IDLE;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            cost_q    <= cost_d;
            credit_q  <= credit_d;
            balance_q <= balance_d;
            timer_q   <= timer_d;
            product_q <= product_d;
            pv_q      <= pv_d;
            cv_q      <= cv_d;
            info_q    <= info_d;
            status_q  <= status_d;
        end
    end

    assign product       = product_q;
    assign product_valid = pv_q;
    assign balance       = balance_q;
    assign change_valid  = cv_q;
    assign info          = info_q;
    assign status        = status_q;

endmodule
